mmap_read_arbiter: RTL and testbench
====================================

Name: mmap_read_arbiter

Overview:
- Shares one async_mmap read channel (read_addr push port, read_data pop port) among NumPorts user-side read requesters.
- Per-port address pushes are buffered and arbitrated round-robin, one address per cycle, into the shared read_addr port.
- Each issued address records its port ID in an in-order tag FIFO.
- Returning read_data beats (one beat per address, in order) are steered back to the owning port using the head tag.

Parameters:
- NumPorts, 4, number of requesters (2..16).
- PortIdWidth, 2, width of port ID; equals $clog2(NumPorts).
- AddrWidth, 64, element-index address width; matches the async_mmap AddrWidth.
- DataWidth, 512, read data width.
- TagDepth, 64, maximum outstanding reads (tag FIFO depth).
- TagDepthLog, 6, log2(TagDepth).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- req_addr_din  in  NumPorts*AddrWidth  per-port read address; port i occupies bits [i*AddrWidth +: AddrWidth].
- req_addr_write  in  NumPorts  per-port push strobe.
- req_addr_full_n  out  NumPorts  per-port not-full.
- resp_data_dout  out  DataWidth  read data, broadcast to all ports.
- resp_data_empty_n  out  NumPorts  per-port data available.
- resp_data_read  in  NumPorts  per-port pop strobe.
- read_addr_din  out  AddrWidth  to the async_mmap read_addr push port.
- read_addr_write  out  1  push strobe to async_mmap.
- read_addr_full_n  in  1  async_mmap read_addr not-full.
- read_data_dout  in  DataWidth  from async_mmap.
- read_data_empty_n  in  1  async_mmap data available.
- read_data_read  out  1  pop strobe to async_mmap.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All skid buffers empty.
  - rr_ptr = 0.
  - Tag FIFO empty; outstanding count = 0.
  - Outputs: req_addr_full_n = all ones, read_addr_write = 0, resp_data_empty_n = 0, read_data_read = 0.
- Reset asserted mid-operation:
  - All state is discarded immediately, including in-flight tags.
  - The integrator must reset async_mmap in the same window; any stale read_data is not routed.
- Per-port input: 2-entry FIFO skid.
  - req_addr_full_n[i] = (count_i != 2), registered-state only; it never depends on req_addr_write.
  - A push when full is ignored.
  - Push and grant in the same cycle are both honoured; count is unchanged.
- Eligibility: port i is eligible when its skid is non-empty.
- Issue condition: any port eligible AND read_addr_full_n AND tag FIFO not full (registered count < TagDepth).
- Grant (combinational): first eligible port scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NumPorts.
- On an issue cycle:
  - read_addr_write = 1; read_addr_din = head of the granted skid; that skid pops.
  - The granted ID is pushed to the tag FIFO.
  - rr_ptr <= (grant+1) mod NumPorts.
- On a non-issue cycle, rr_ptr holds.
- Latency: an address pushed into an empty skid appears on read_addr_din the next cycle at the earliest.
- Throughput: 1 address per cycle aggregate; 1 per cycle for a single port.
- Response routing (h = tag FIFO head):
  - resp_data_empty_n[h] = read_data_empty_n AND tag FIFO non-empty; all other bits are 0.
  - resp_data_dout = read_data_dout.
  - read_data_read = resp_data_read[h] AND resp_data_empty_n[h]; the tag FIFO pops on the same cycle.
  - resp_data_read on non-head ports is ignored.
  - Combinational response path: zero added latency.
- Tag FIFO full: issue stalls, grant is withheld and rr_ptr holds.
  - A push and a pop in the same cycle while full: the push is still blocked (full is evaluated from registered count).
  - A push and a pop in the same cycle when not full: count unchanged.
- read_data_empty_n high with tag FIFO empty: protocol violation. Nothing is routed; read_data_read = 0; simulation assertion fires.
- Address values pass through unmodified. No width conversion or offset; the offset is applied inside async_mmap.
- Head-of-line blocking is inherent: a stalled consumer at the head tag blocks every other port's data.

Decomposition:
- No shared package. PortIdWidth and TagDepthLog are parameters checked by an elaboration-time assertion against $clog2.
- One sub-module, mmap_tag_fifo:
  - Synchronous FIFO with parameters Width = PortIdWidth, Depth = TagDepth, DepthLog = TagDepthLog.
  - Asynchronous active-low reset; full/empty from registered count.
- The per-port 2-entry skid is reused as NumPorts instances of the same module with Width = AddrWidth, Depth = 2.
- The arbiter and router stay in the top module.

Test Plan:
- Single port: port 0 pushes addrs 0,1,2,3 back-to-back; downstream always ready; data returns D0..D3. Expect read_addr_din = 0,1,2,3 on 4 consecutive cycles; port 0 receives D0..D3 in order; other empty_n stay 0.
- Round-robin fairness: all 4 ports hold 2 addrs each (port i addrs 10i, 10i+1), issuing from rr_ptr=0. Expect issue order 0,10,20,30,1,11,21,31; data is routed to ports 0,1,2,3,0,1,2,3.
- Downstream backpressure: read_addr_full_n low for 5 cycles with ports 1 and 3 pending. Expect no read_addr_write and rr_ptr held. On release, port 1 is issued first, then port 3.
- Tag FIFO full: TagDepth=4, responses withheld, 6 addrs pushed. Expect exactly 4 issued, then stall. Pop one beat → one more issue next cycle.
- Head-of-line: tags [2,0]; port 2 holds resp_data_read low for 3 cycles while port 0 asserts read. Expect no pop and resp_data_empty_n = 4'b0100. After port 2 reads, port 0 receives its beat.
- Async reset mid-burst: 3 reads outstanding, rst_n low for half a cycle. Expect immediate resp_data_empty_n = 0, read_addr_write = 0, full_n = all ones; normal issue resumes after release.

Source files
------------

// File: rtl/mmap_tag_fifo.sv
// Synchronous FIFO with registered-count full/empty. Serves as the in-order
// read tag queue and as the per-port 2-entry address skid.
module mmap_tag_fifo #(
  parameter int Width    = 2,
  parameter int Depth    = 64,
  parameter int DepthLog = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  output logic             full_n_o,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic             empty_n_o
);

  if (Depth != (1 << DepthLog)) begin : g_bad_depth
    $error("mmap_tag_fifo: Depth must equal 2**DepthLog");
  end

  logic [Width-1:0]    mem_q [Depth];
  logic [DepthLog-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog:0]   cnt_q, cnt_d;
  logic                do_push, do_pop;

  // Full/empty come only from registered state, so a pop never frees a slot
  // for a push in the same cycle.
  assign full_n_o  = (cnt_q != (DepthLog+1)'(Depth));
  assign empty_n_o = (cnt_q != '0);
  assign do_push   = push_i & full_n_o;
  assign do_pop    = pop_i & empty_n_o;
  assign dout_o    = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (DepthLog+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (DepthLog+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DepthLog'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DepthLog'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mmap_read_arbiter.sv
// Shares one async_mmap read channel among NumPorts requesters: round-robin
// address issue, in-order tag FIFO steering the returning data beats.
module mmap_read_arbiter #(
  parameter int NumPorts    = 4,
  parameter int PortIdWidth = 2,
  parameter int AddrWidth   = 64,
  parameter int DataWidth   = 512,
  parameter int TagDepth    = 64,
  parameter int TagDepthLog = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_din,
  input  logic [NumPorts-1:0]           req_addr_write,
  output logic [NumPorts-1:0]           req_addr_full_n,
  output logic [DataWidth-1:0]          resp_data_dout,
  output logic [NumPorts-1:0]           resp_data_empty_n,
  input  logic [NumPorts-1:0]           resp_data_read,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  input  logic                          read_data_empty_n,
  output logic                          read_data_read
);

  if (PortIdWidth != $clog2(NumPorts)) begin : g_bad_pid
    $error("mmap_read_arbiter: PortIdWidth must equal $clog2(NumPorts)");
  end
  if (TagDepthLog != $clog2(TagDepth)) begin : g_bad_tag
    $error("mmap_read_arbiter: TagDepthLog must equal $clog2(TagDepth)");
  end

  logic [NumPorts-1:0][AddrWidth-1:0] skid_dout;
  logic [NumPorts-1:0]                elig, skid_pop;
  logic [PortIdWidth-1:0]             rr_ptr_q, rr_ptr_d, grant, tag_head;
  logic                               grant_vld, issue, tag_full_n, tag_empty_n, rsp_vld;

  for (genvar i = 0; i < NumPorts; i++) begin : g_skid
    mmap_tag_fifo #(.Width(AddrWidth), .Depth(2), .DepthLog(1)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (req_addr_write[i]),
      .din_i     (req_addr_din[i*AddrWidth +: AddrWidth]),
      .full_n_o  (req_addr_full_n[i]),
      .pop_i     (skid_pop[i]),
      .dout_o    (skid_dout[i]),
      .empty_n_o (elig[i])
    );
  end

  // First eligible port at or after rr_ptr, wrapping.
  always_comb begin : p_grant
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < NumPorts; k++) begin
      idx = (int'(rr_ptr_q) + k) % NumPorts;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = PortIdWidth'(idx);
      end
    end
  end

  assign issue           = grant_vld & read_addr_full_n & tag_full_n;
  assign read_addr_write = issue;
  assign read_addr_din   = skid_dout[grant];

  always_comb begin
    skid_pop = '0;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      skid_pop[grant] = 1'b1;
      rr_ptr_d        = PortIdWidth'((int'(grant) + 1) % NumPorts);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  mmap_tag_fifo #(.Width(PortIdWidth), .Depth(TagDepth), .DepthLog(TagDepthLog)) u_tag (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (issue),
    .din_i     (grant),
    .full_n_o  (tag_full_n),
    .pop_i     (read_data_read),
    .dout_o    (tag_head),
    .empty_n_o (tag_empty_n)
  );

  // Only the head-tag owner sees data; everyone else waits behind it.
  assign rsp_vld        = read_data_empty_n & tag_empty_n;
  assign resp_data_dout = read_data_dout;
  assign read_data_read = rsp_vld & resp_data_read[tag_head];

  always_comb begin
    resp_data_empty_n = '0;
    if (rsp_vld) resp_data_empty_n[tag_head] = 1'b1;
  end

  a_no_orphan_data: assert property (@(posedge clk) disable iff (!rst_n)
    !(read_data_empty_n && !tag_empty_n));

endmodule

// File: tb/tb_mmap_read_arbiter.sv
// Directed bench for mmap_read_arbiter with a small in-order async_mmap read model.
module tb_mmap_read_arbiter;
  localparam int NP = 4, AW = 64, DW = 512, TD = 4, TDL = 2;

  logic clk = 1'b0, rst_n = 1'b0, mm_rst_n = 1'b0;
  logic [NP-1:0][AW-1:0] req_din = '0;
  logic [NP-1:0] req_wr = '0, req_full_n, resp_empty_n, resp_rd = '0;
  logic [DW-1:0] resp_dout, rd_dout;
  logic [AW-1:0] ra_din;
  logic ra_wr, ra_full_n = 1'b1, rd_empty_n, rd_rd;
  logic resp_en = 1'b0;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  mmap_read_arbiter #(
    .NumPorts(NP), .PortIdWidth(2), .AddrWidth(AW), .DataWidth(DW),
    .TagDepth(TD), .TagDepthLog(TDL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr_din(req_din), .req_addr_write(req_wr), .req_addr_full_n(req_full_n),
    .resp_data_dout(resp_dout), .resp_data_empty_n(resp_empty_n), .resp_data_read(resp_rd),
    .read_addr_din(ra_din), .read_addr_write(ra_wr), .read_addr_full_n(ra_full_n),
    .read_data_dout(rd_dout), .read_data_empty_n(rd_empty_n), .read_data_read(rd_rd)
  );

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {8{a ^ 64'hC0DE_0000_0000_0000}};
  endfunction

  // async_mmap read model: one beat per accepted address, in order.
  logic [AW-1:0] mq [0:63];
  logic [5:0] mwr, mrd;
  always @(posedge clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      mwr <= '0;
      mrd <= '0;
    end else begin
      if (ra_wr && ra_full_n) begin
        mq[mwr] <= ra_din;
        mwr <= mwr + 6'd1;
      end
      if (rd_rd && rd_empty_n) mrd <= mrd + 6'd1;
    end
  end
  assign rd_empty_n = resp_en && (mwr != mrd);
  assign rd_dout    = dat(mq[mrd]);

  task automatic do_reset();
    req_wr = '0; resp_rd = '0; resp_en = 1'b0; ra_full_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; mm_rst_n = 1'b0;
    #3;
    rst_n = 1'b1; mm_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    nvec++; if (req_full_n !== 4'b1111) begin nerr++; $display("FAIL reset_full_n got %b exp 1111", req_full_n); end
    nvec++; if (ra_wr !== 1'b0) begin nerr++; $display("FAIL reset_read_addr_write got %b exp 0", ra_wr); end
    nvec++; if (resp_empty_n !== 4'b0000) begin nerr++; $display("FAIL reset_resp_empty_n got %b exp 0000", resp_empty_n); end
    nvec++; if (rd_rd !== 1'b0) begin nerr++; $display("FAIL reset_read_data_read got %b exp 0", rd_rd); end
    @(posedge clk); #2;
    rst_n = 1'b1; mm_rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    logic ew; logic [3:0] ee;
    do_reset();
    resp_en = 1'b1; resp_rd = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_wr = (c < 4) ? 4'b0001 : 4'b0000;
      req_din[0] = 64'(c);
      #1;
      ew = (c >= 1 && c <= 4);
      nvec++;
      if (ra_wr !== ew || (ew && ra_din !== 64'(c-1))) begin
        nerr++; $display("FAIL single_issue c=%0d got wr=%b addr=%0h exp wr=%b addr=%0h", c, ra_wr, ra_din, ew, c-1);
      end
      ee = (c >= 2 && c <= 5) ? 4'b0001 : 4'b0000;
      nvec++;
      if (resp_empty_n !== ee || (ee != 0 && resp_dout !== dat(64'(c-2)))) begin
        nerr++; $display("FAIL single_resp c=%0d got empty_n=%b data=%0h exp empty_n=%b data=%0h",
                         c, resp_empty_n, resp_dout[63:0], ee, dat(64'(c-2)) & 512'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    req_wr = '0;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_a [8];
    logic [3:0] ee;
    exp_a = '{64'd0, 64'd10, 64'd20, 64'd30, 64'd1, 64'd11, 64'd21, 64'd31};
    do_reset();
    resp_en = 1'b1; resp_rd = 4'b1111; ra_full_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_wr = 4'b1111;
      for (int i = 0; i < NP; i++) req_din[i] = (c == 2) ? 64'd99 : 64'(10*i + c);
      #1;
      nvec++; if (ra_wr !== 1'b0) begin nerr++; $display("FAIL rr_hold c=%0d got wr=%b exp 0", c, ra_wr); end
      if (c == 1) begin
        nvec++; if (req_full_n !== 4'b1111) begin nerr++; $display("FAIL rr_full_n_one got %b exp 1111", req_full_n); end
      end
      if (c == 2) begin
        nvec++; if (req_full_n !== 4'b0000) begin nerr++; $display("FAIL rr_full_n_two got %b exp 0000", req_full_n); end
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req_wr = '0; ra_full_n = 1'b1;
      #1;
      nvec++;
      if (k < 8) begin
        if (ra_wr !== 1'b1 || ra_din !== exp_a[k]) begin
          nerr++; $display("FAIL rr_issue k=%0d got wr=%b addr=%0d exp wr=1 addr=%0d", k, ra_wr, ra_din, exp_a[k]);
        end
      end else if (ra_wr !== 1'b0) begin
        nerr++; $display("FAIL rr_issue_done k=%0d got wr=%b exp 0", k, ra_wr);
      end
      ee = (k >= 1 && k <= 8) ? 4'(1 << ((k-1) % 4)) : 4'b0000;
      nvec++;
      if (resp_empty_n !== ee || (ee != 0 && resp_dout !== dat(exp_a[k-1]))) begin
        nerr++; $display("FAIL rr_route k=%0d got empty_n=%b data=%0h exp empty_n=%b", k, resp_empty_n, resp_dout[63:0], ee);
      end
    end
  endtask

  task automatic test_backpressure();
    // per cycle: push mask, downstream full_n, expected write/addr, expected routing/addr
    logic [3:0]    push_t [11] = '{4'b0001, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic          fn_t   [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic          ew_t   [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] ea_t   [11] = '{64'd0, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd100, 64'd300, 64'd0, 64'd0};
    logic [3:0]    ee_t   [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0000};
    logic [AW-1:0] ed_t   [11] = '{64'd0, 64'd0, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd100, 64'd300, 64'd0};
    do_reset();
    resp_en = 1'b1; resp_rd = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      req_wr = push_t[c]; ra_full_n = fn_t[c];
      req_din[0] = 64'd5; req_din[1] = 64'd100; req_din[3] = 64'd300;
      #1;
      nvec++;
      if (ra_wr !== ew_t[c] || (ew_t[c] && ra_din !== ea_t[c])) begin
        nerr++; $display("FAIL bp_issue c=%0d got wr=%b addr=%0d exp wr=%b addr=%0d", c, ra_wr, ra_din, ew_t[c], ea_t[c]);
      end
      nvec++;
      if (resp_empty_n !== ee_t[c] || (ee_t[c] != 0 && resp_dout !== dat(ed_t[c]))) begin
        nerr++; $display("FAIL bp_route c=%0d got empty_n=%b exp %b", c, resp_empty_n, ee_t[c]);
      end
    end
  endtask

  task automatic test_tag_full();
    logic ew; logic [AW-1:0] ea;
    do_reset();
    resp_rd = 4'b0001;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      req_wr = (c < 6) ? 4'b0001 : 4'b0000;
      req_din[0] = 64'h40 + 64'(c);
      resp_en = (c == 8);
      #1;
      ew = (c >= 1 && c <= 4) || (c == 9);
      ea = (c == 9) ? 64'h44 : 64'h40 + 64'(c-1);
      nvec++;
      if (ra_wr !== ew || (ew && ra_din !== ea)) begin
        nerr++; $display("FAIL tag_full_issue c=%0d got wr=%b addr=%0h exp wr=%b addr=%0h", c, ra_wr, ra_din, ew, ea);
      end
      if (c == 7) begin
        nvec++; if (req_full_n[0] !== 1'b0) begin nerr++; $display("FAIL tag_full_skid got full_n=%b exp 0", req_full_n[0]); end
        nvec++; if (resp_empty_n !== 4'b0000) begin nerr++; $display("FAIL tag_full_withheld got %b exp 0000", resp_empty_n); end
      end
      if (c == 8) begin
        nvec++;
        if (resp_empty_n !== 4'b0001 || rd_rd !== 1'b1 || resp_dout !== dat(64'h40)) begin
          nerr++; $display("FAIL tag_full_pop got empty_n=%b rd=%b data=%0h exp 0001 1", resp_empty_n, rd_rd, resp_dout[63:0]);
        end
      end
    end
  endtask

  task automatic test_head_of_line();
    logic [3:0] rd_t [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0001};
    logic [3:0] ee_t [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
    logic       er_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] ed;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      req_wr = (c == 0) ? 4'b0100 : (c == 1) ? 4'b0001 : 4'b0000;
      req_din[2] = 64'h22; req_din[0] = 64'h02;
      resp_en = (c >= 3); resp_rd = rd_t[c];
      #1;
      if (c == 1 || c == 2) begin
        nvec++;
        if (ra_wr !== 1'b1 || ra_din !== ((c == 1) ? 64'h22 : 64'h02)) begin
          nerr++; $display("FAIL hol_issue c=%0d got wr=%b addr=%0h", c, ra_wr, ra_din);
        end
      end
      ed = (c == 7) ? 64'h02 : 64'h22;
      nvec++;
      if (resp_empty_n !== ee_t[c] || rd_rd !== er_t[c] || (ee_t[c] != 0 && resp_dout !== dat(ed))) begin
        nerr++; $display("FAIL hol_route c=%0d got empty_n=%b rd=%b exp empty_n=%b rd=%b", c, resp_empty_n, rd_rd, ee_t[c], er_t[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    resp_en = 1'b1; resp_rd = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      req_wr = (c < 3) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      req_din[0] = 64'h60 + 64'(c); req_din[1] = 64'h77;
      #1;
    end
    nvec++;
    if (ra_wr !== 1'b1 || ra_din !== 64'h77 || resp_empty_n !== 4'b0001) begin
      nerr++; $display("FAIL arst_pre got wr=%b addr=%0h empty_n=%b exp 1 77 0001", ra_wr, ra_din, resp_empty_n);
    end
    rst_n = 1'b0;
    #1;
    nvec++; if (resp_empty_n !== 4'b0000) begin nerr++; $display("FAIL arst_resp_empty_n got %b exp 0000", resp_empty_n); end
    nvec++; if (ra_wr !== 1'b0) begin nerr++; $display("FAIL arst_read_addr_write got %b exp 0", ra_wr); end
    nvec++; if (req_full_n !== 4'b1111) begin nerr++; $display("FAIL arst_full_n got %b exp 1111", req_full_n); end
    mm_rst_n = 1'b0;
    #4;
    rst_n = 1'b1; mm_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_wr = (c == 0) ? 4'b0100 : 4'b0000;
      req_din[2] = 64'h99; resp_rd = 4'b0100;
      #1;
      nvec++;
      if (ra_wr !== (c == 1) || (c == 1 && ra_din !== 64'h99)) begin
        nerr++; $display("FAIL arst_resume_issue c=%0d got wr=%b addr=%0h", c, ra_wr, ra_din);
      end
      nvec++;
      if (resp_empty_n !== ((c == 2) ? 4'b0100 : 4'b0000) || (c == 2 && resp_dout !== dat(64'h99))) begin
        nerr++; $display("FAIL arst_resume_route c=%0d got empty_n=%b", c, resp_empty_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_tag_full();
    test_head_of_line();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
